// File: rtl/fanout_fork_ctrl_if.sv
// Fork controller bundle: config, producer side and per-branch consumer side.
// Optional FANOUT_STALL_CNT_EN adds the stall_cnt observation signal.
interface fanout_fork_ctrl_if #(
    parameter int NUM_BRANCH = 7,
    parameter int DATA_WIDTH = 16
);
    logic                  cfg_wr;
    logic [NUM_BRANCH-1:0] cfg_data;
    logic [NUM_BRANCH-1:0] cfg_mask;
    logic                  flush;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [NUM_BRANCH-1:0] out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [NUM_BRANCH-1:0] out_ready;
`ifdef FANOUT_STALL_CNT_EN
    logic [31:0]           stall_cnt;
`endif

    modport master (
        output cfg_wr, cfg_data, flush, in_valid, in_data, out_ready,
        input  cfg_mask, in_ready, out_valid, out_data
`ifdef FANOUT_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  cfg_wr, cfg_data, flush, in_valid, in_data, out_ready,
        output cfg_mask, in_ready, out_valid, out_data
`ifdef FANOUT_STALL_CNT_EN
        , output stall_cnt
`endif
    );
endinterface

// File: rtl/fanout_fork_ctrl.sv
// Eager fork: one producer token broadcast to every enabled branch, each accepting once.
// Latency: zero (out_valid/in_ready combinational); done/mask update on the next clk edge.
// Backpressure: in_ready held low until every still-pending branch is ready. Option: FANOUT_STALL_CNT_EN.
module fanout_fork_ctrl #(
    parameter int NUM_BRANCH = 7,
    parameter int DATA_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fanout_fork_ctrl_if.slave  bus
);
    logic [NUM_BRANCH-1:0] mask_q;
    logic [NUM_BRANCH-1:0] done_q;
    logic [NUM_BRANCH-1:0] pend;
    logic [NUM_BRANCH-1:0] out_valid_c;
    logic                  in_ready_c;
    logic                  fire;

    always_comb begin
        pend        = mask_q & ~done_q;
        out_valid_c = {NUM_BRANCH{bus.in_valid}} & pend;
        // Deliberately independent of in_valid so an empty mask drains tokens.
        in_ready_c  = &(~pend | bus.out_ready);
        fire        = bus.in_valid & in_ready_c;
    end

    assign bus.cfg_mask  = mask_q;
    assign bus.out_valid = out_valid_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = bus.in_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= '0;
            done_q <= '0;
        end else begin
            if (bus.cfg_wr) begin
                mask_q <= bus.cfg_data;
            end
            // A mask change restarts any in-flight token from scratch.
            if (bus.cfg_wr || bus.flush || fire) begin
                done_q <= '0;
            end else begin
                done_q <= done_q | (out_valid_c & bus.out_ready);
            end
        end
    end

`ifdef FANOUT_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            stall_cnt_q <= '0;
        end else if (bus.in_valid && !in_ready_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Directed bench for fanout_fork_ctrl: hand-computed expectations checked between clock edges.
// Stall counter checks are active only when FANOUT_STALL_CNT_EN is defined.
module tb_fanout_fork_ctrl;
    localparam int NB = 7;
    localparam int DW = 16;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    fanout_fork_ctrl_if #(.NUM_BRANCH(NB), .DATA_WIDTH(DW)) bus ();

    fanout_fork_ctrl #(.NUM_BRANCH(NB), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mask(input logic [NB-1:0] m);
        bus.cfg_wr   = 1'b1;
        bus.cfg_data = m;
        step();
        bus.cfg_wr   = 1'b0;
        #1;
        check("cfg_mask", 32'(bus.cfg_mask), 32'(m));
    endtask

    initial begin
        int acc0;
        int fires;
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.cfg_wr    = 1'b0;
        bus.cfg_data  = '0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        step();
        step();
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_mask", 32'(bus.cfg_mask), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
`ifdef FANOUT_STALL_CNT_EN
        check("rst_stall_cnt", bus.stall_cnt, 32'h0);
`endif

        // Empty mask drains tokens
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.in_data = 16'(16'h1000 + c);
            #1;
            check("empty_in_ready", 32'(bus.in_ready), 32'h1);
            check("empty_out_valid", 32'(bus.out_valid), 32'h0);
            step();
        end
        bus.in_valid = 1'b0;

        // Single-cycle fire on all branches
        load_mask(7'h7F);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hBEEF;
        bus.out_ready = 7'h7F;
        #1;
        check("all_out_valid", 32'(bus.out_valid), 32'h7F);
        check("all_in_ready", 32'(bus.in_ready), 32'h1);
        check("all_out_data", 32'(bus.out_data), 32'hBEEF);
        step();
        bus.out_ready = 7'h00;
        bus.in_data   = 16'hCAFE;
        #1;
        check("all_done_clear", 32'(bus.out_valid), 32'h7F);
        check("all_stall_rdy", 32'(bus.in_ready), 32'h0);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        step();
        bus.flush = 1'b0;

        // Staggered accept
        load_mask(7'h0B);
        bus.out_ready = 7'h0B;
        #1;
        check("rdy_no_valid", 32'(bus.in_ready), 32'h1);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        bus.out_ready = 7'h01;
        #1;
        check("stag0_out_valid", 32'(bus.out_valid), 32'h0B);
        check("stag0_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        bus.out_ready = 7'h08;
        #1;
        check("stag1_out_valid", 32'(bus.out_valid), 32'h0A);
        check("stag1_in_ready", 32'(bus.in_ready), 32'h0);
        check("stag1_out_data", 32'(bus.out_data), 32'h1234);
        step();
        bus.out_ready = 7'h02;
        #1;
        check("stag2_out_valid", 32'(bus.out_valid), 32'h02);
        check("stag2_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.out_ready = 7'h00;
        bus.in_data   = 16'h5678;
        #1;
        check("stag_next_valid", 32'(bus.out_valid), 32'h0B);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        step();
        bus.flush = 1'b0;

        // Back-to-back tokens, branch 2 ready every other cycle
        load_mask(7'h05);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            acc0  = 0;
            fires = 0;
            bus.in_data = 16'(16'hA0 + k);
            for (int c = 0; c < 2; c++) begin
                bus.out_ready = (c == 1) ? 7'h05 : 7'h01;
                #1;
                check("b2b_out_valid", 32'(bus.out_valid), (c == 1) ? 32'h04 : 32'h05);
                check("b2b_out_data", 32'(bus.out_data), 32'(16'hA0 + k));
                if (bus.out_valid[0] && bus.out_ready[0]) acc0++;
                if (bus.in_valid && bus.in_ready) fires++;
                step();
            end
            check("b2b_br0_accepts", 32'(acc0), 32'h1);
            check("b2b_fires", 32'(fires), 32'h1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 7'h00;

        // Flush mid-token
        load_mask(7'h03);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0F0F;
        bus.out_ready = 7'h01;
        step();
        bus.out_ready = 7'h00;
        #1;
        check("flush_pre_valid", 32'(bus.out_valid), 32'h02);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        #1;
        check("flush_post_valid", 32'(bus.out_valid), 32'h03);
`ifdef FANOUT_STALL_CNT_EN
        check("flush_stall_cnt", bus.stall_cnt, 32'h0);
`endif
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        step();
        bus.flush = 1'b0;

        // Stall counter: 10 stalled cycles then fire
        load_mask(7'h01);
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h7777;
        bus.out_ready = 7'h00;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c == 0 || c == 9) check("stall_in_ready", 32'(bus.in_ready), 32'h0);
            step();
        end
        bus.out_ready = 7'h01;
        #1;
        check("stall_fire_rdy", 32'(bus.in_ready), 32'h1);
`ifdef FANOUT_STALL_CNT_EN
        check("stall_cnt_10", bus.stall_cnt, 32'd10);
`endif
        step();
        bus.in_valid = 1'b0;
        #1;
`ifdef FANOUT_STALL_CNT_EN
        check("stall_cnt_hold", bus.stall_cnt, 32'd10);
`endif

        // cfg_wr together with flush, then reset mid-token
        bus.cfg_wr   = 1'b1;
        bus.cfg_data = 7'h03;
        bus.flush    = 1'b1;
        step();
        bus.cfg_wr = 1'b0;
        bus.flush  = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 7'h01;
        #1;
        check("cfgfl_mask", 32'(bus.cfg_mask), 32'h03);
        check("cfgfl_out_valid", 32'(bus.out_valid), 32'h03);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("midrst_mask", 32'(bus.cfg_mask), 32'h0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'h1);
        bus.in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fanout_fork_ctrl.md
Name: fanout_fork_ctrl

Overview:
Eager-fork controller for one producer driving up to NUM_BRANCH consumers over ready/valid.
- Tracks which enabled branches have already taken the current token.
- Re-presents valid only to branches that still owe an accept.
- Returns a single in_ready to the producer once every enabled branch has accepted.
- Sits between a tile output port and its fanout interconnect switches; the branch mask comes from a config register write.

Parameters:
NUM_BRANCH, 7, number of fanout branches (1..16)
DATA_WIDTH, 16, payload width, passed through unmodified

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfg_wr  in  1  config write strobe
cfg_data  in  NUM_BRANCH  branch enable mask to load
cfg_mask  out  NUM_BRANCH  current branch enable mask
flush  in  1  synchronous clear of per-branch accept state
in_valid  in  1  producer token valid
in_data  in  DATA_WIDTH  producer payload
in_ready  out  1  token fully consumed this cycle
out_valid  out  NUM_BRANCH  per-branch valid
out_data  out  DATA_WIDTH  broadcast payload (= in_data)
out_ready  in  NUM_BRANCH  per-branch ready

Behaviour:
- Reset (rst_n=0 at clk edge): mask=0, done=0, stall counter=0.
  - Outputs after reset: out_valid=0 and in_ready=1 (empty mask).
- Per-branch pending: pend[i] = mask[i] & ~done[i].
- out_valid[i] = in_valid & pend[i]; combinational, zero latency.
- in_ready = AND over i of (~pend[i] | out_ready[i]); combinational.
  - Does not depend on in_valid.
- Fire = in_valid & in_ready.
- done update, at clk edge, in priority order:
  1. ~rst_n: done=0.
  2. cfg_wr or flush: done=0.
  3. Fire: done=0, so the next token starts fresh.
  4. Otherwise: done[i] |= out_valid[i] & out_ready[i].
- Per-branch handshake: each branch sees at most one out_valid&out_ready per token.
- Stall hold: while in_valid=1 and in_ready=0, out_valid and out_data must hold.
  - Producer obligation: in_data stable until fire.
- Empty mask: in_ready=1 and out_valid=0; tokens are drained and dropped.
- All pending branches ready in the same cycle: fire in one cycle, done stays 0.
- Token spanning N cycles: accepted branches drop out_valid the cycle after their accept; in_ready rises when the last pending branch is ready.
- cfg_wr: mask<=cfg_data on the next edge.
  - A token in flight restarts under the new mask; branches that already accepted will see it again (documented re-send).
  - Software must only reconfigure while idle.
- cfg_wr with flush in the same cycle: mask loads and done clears.
- flush with in_valid in the same cycle: fire is still evaluated combinationally that cycle; done clears regardless.
- Reset mid-token: done clears and the producer must re-present.

Optional Feature:
FANOUT_STALL_CNT_EN
- Defined: adds output stall_cnt [31:0].
  - Increments each cycle with in_valid=1 and in_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset or flush; not cleared by cfg_wr.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Empty mask: reset, in_valid=1, mask=0 -> in_ready=1, out_valid=0 every cycle.
- Single-cycle fire: mask=7'h7F, out_ready=7'h7F, in_valid=1 -> fire in the same cycle, out_valid=7'h7F, done stays 0.
- Staggered accept: mask=7'h0B, out_ready=7'h01 in cycle 0, 7'h08 in cycle 1, 7'h02 in cycle 2.
  - out_valid: 7'h0B, then 7'h0A, then 7'h02.
  - in_ready=1 only in cycle 2; next token sees out_valid=7'h0B.
- Back-to-back: 4 tokens, mask=7'h05, branch 2 ready every other cycle -> each token fires exactly once, branch 0 accepts each token exactly once, in_data order preserved.
- Flush mid-token: mask=7'h03, branch 0 accepts, then flush=1 -> next cycle out_valid=7'h03 again.
  - With FANOUT_STALL_CNT_EN: stall_cnt=0 after flush.
- Stall counter: mask=7'h01, out_ready=0, in_valid=1 for 10 cycles, then ready -> stall_cnt=10, unchanged after the fire cycle.
